// File: rtl/pwm_duty_req_tx.sv
// Source side of the 4-phase req/ack CDC handshake that delivers PWM duty words.
// Ports: clk, rst (async, active-high); wr_valid/wr_data/wr_ready write accept;
//   req/tx_data/ack handshake to the PWM domain; busy, done (pulse), timeout (sticky).
// Optional: define PWM_DUTY_PENDING_BUF_EN for a one-entry coalescing pending register.
module pwm_duty_req_tx #(
    parameter int DATA_WIDTH  = 12,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  req,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  ack,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic                   req_q, req_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   done_q, done_d;
    logic                   to_q, to_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   launch;
    logic [DATA_WIDTH-1:0]  launch_data;

    assign ack_s = sync_q[SYNC_STAGES-1];

`ifdef PWM_DUTY_PENDING_BUF_EN
    logic                  pend_v_q, pend_v_d;
    logic [DATA_WIDTH-1:0] pend_q, pend_d;

    // A pending word always has priority over the write on the bus; that
    // write then refills the pending slot instead of being lost.
    assign wr_ready    = ~rst;
    assign launch      = (state_q == IDLE) && !ack_s && (pend_v_q || wr_valid);
    assign launch_data = pend_v_q ? pend_q : wr_data;

    always_comb begin
        pend_v_d = pend_v_q;
        pend_d   = pend_q;
        if (launch && pend_v_q) begin
            pend_v_d = 1'b0;
        end
        if (wr_valid && !(launch && !pend_v_q)) begin
            pend_v_d = 1'b1;
            pend_d   = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v_q <= 1'b0;
            pend_q   <= '0;
        end else begin
            pend_v_q <= pend_v_d;
            pend_q   <= pend_d;
        end
    end
`else
    assign wr_ready    = (state_q == IDLE) && !ack_s;
    assign launch      = wr_valid && wr_ready;
    assign launch_data = wr_data;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = REQ_HI;
                    req_d   = 1'b1;
                    data_d  = launch_data;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    state_d = REQ_LO;
                    req_d   = 1'b0;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Phase watchdog: restarts on each state change, saturates at the limit.
    // The flag is only a report; the handshake keeps waiting.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != IDLE && cnt_q != TO_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
        to_d = to_q | (cnt_d == TO_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= '0;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], ack};
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req     = req_q;
    assign tx_data = data_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign timeout = to_q;

endmodule
